// File: rtl/hyper_pkg.sv
// Shared definitions for the HyperBus responder: FSM states, CA field positions,
// register addresses and the wrapped-burst length decode.
package hyper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CA,
      ST_LAT,
      ST_REG_WR,
      ST_RD,
      ST_WR
   } hyper_state_t;

   localparam int unsigned CA_RW_BIT = 47;
   localparam int unsigned CA_AS_BIT = 46;
   localparam int unsigned CA_BT_BIT = 45;
   localparam int unsigned CA_BYTES  = 6;

   localparam logic [11:0] REG_ID0_ADDR = 12'h000;
   localparam logic [11:0] REG_CR0_ADDR = 12'h800;

   // Word-offset mask of the aligned wrap group selected by CR0[1:0].
   function automatic logic [31:0] wrap_mask(input logic [1:0] burst_len);
      case (burst_len)
         2'b00:   return 32'd63;
         2'b01:   return 32'd31;
         2'b10:   return 32'd7;
         default: return 32'd15;
      endcase
   endfunction

endpackage

// File: rtl/hyper_edge_sync.sv
// Brings the HyperBus pins into the clk domain: 2-flop sync of cs_l/ck, DQ/RWDS
// delayed by the same two stages, and a one-clk pulse per CK transition.
module hyper_edge_sync (
   input  logic       clk,
   input  logic       reset_l,
   input  logic       cs_l,
   input  logic       ck,
   input  logic [7:0] dq,
   input  logic       rwds,
   output logic       cs_l_s,
   output logic [7:0] dq_s,
   output logic       rwds_s,
   output logic       ck_edge
);

   logic [1:0] cs_sync;
   logic [1:0] ck_sync;
   logic       ck_q;
   logic [7:0] dq_d1;
   logic       rwds_d1;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cs_sync <= '1;
         ck_sync <= '0;
         ck_q    <= 1'b0;
         dq_d1   <= '0;
         dq_s    <= '0;
         rwds_d1 <= 1'b0;
         rwds_s  <= 1'b0;
      end else begin
         cs_sync <= {cs_sync[0], cs_l};
         ck_sync <= {ck_sync[0], ck};
         ck_q    <= ck_sync[1];
         dq_d1   <= dq;
         dq_s    <= dq_d1;
         rwds_d1 <= rwds;
         rwds_s  <= rwds_d1;
      end
   end

   assign cs_l_s  = cs_sync[1];
   assign ck_edge = ck_sync[1] ^ ck_q;

endmodule

// File: rtl/hyper_target.sv
// HyperRAM memory-end responder: decodes the 48-bit CA from oversampled CK edges and
// serves DDR reads/writes from two byte-lane arrays plus the CR0/ID0 registers.
module hyper_target
   import hyper_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned LAT_CLKS = 6,
   parameter logic [15:0] ID0_VAL  = 16'h0C81,
   parameter logic [15:0] CR0_RST  = 16'h8F1F
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        dram_cs_l,
   input  logic        dram_ck,
   input  logic [7:0]  dram_dq_in,
   output logic [7:0]  dram_dq_out,
   output logic        dram_dq_oe_l,
   input  logic        dram_rwds_in,
   output logic        dram_rwds_out,
   output logic        dram_rwds_oe_l,
   output logic [15:0] cr0
);

   localparam int unsigned MEM_WORDS = 1 << ADDR_W;
   localparam logic [7:0]  CA_LAST   = 8'(CA_BYTES - 1);
   localparam logic [7:0]  LAT_LAST  = 8'(4 * LAT_CLKS - 3);

   logic         cs_l_s;
   logic [7:0]   dq_s;
   logic         rwds_s;
   logic         ck_edge;

   hyper_state_t state;
   logic [7:0]   cnt;
   logic [39:0]  ca;
   logic [31:0]  addr;
   logic         is_rd;
   logic         is_reg;
   logic         is_wrap;
   logic         phase;
   logic [7:0]   reg_hi;

   logic [7:0]   mem_hi [MEM_WORDS];
   logic [7:0]   mem_lo [MEM_WORDS];

   logic [47:0]  ca_full;
   logic [31:0]  ca_addr;
   logic [31:0]  wmask;
   logic [31:0]  addr_next;
   logic [ADDR_W-1:0] idx;
   logic [15:0]  rd_word;
   logic         mem_wr_hi;
   logic         mem_wr_lo;
   logic         ca_unused;

   hyper_edge_sync u_sync (
      .clk     (clk),
      .reset_l (reset_l),
      .cs_l    (dram_cs_l),
      .ck      (dram_ck),
      .dq      (dram_dq_in),
      .rwds    (dram_rwds_in),
      .cs_l_s  (cs_l_s),
      .dq_s    (dq_s),
      .rwds_s  (rwds_s),
      .ck_edge (ck_edge)
   );

   always_comb begin
      ca_full   = {ca, dq_s};
      ca_addr   = {ca_full[44:16], ca_full[2:0]};
      ca_unused = ^ca_full[15:3];
      idx       = addr[ADDR_W-1:0];
      wmask     = wrap_mask(cr0[1:0]);
      // Linear bursts wrap at the array end simply because only the low bits index it.
      if (is_wrap) addr_next = (addr & ~wmask) | ((addr + 32'd1) & wmask);
      else         addr_next = addr + 32'd1;
      if (is_reg) begin
         case (addr[11:0])
            REG_ID0_ADDR: rd_word = ID0_VAL;
            REG_CR0_ADDR: rd_word = cr0;
            default:      rd_word = '0;
         endcase
      end else begin
         rd_word = {mem_hi[idx], mem_lo[idx]};
      end
      mem_wr_hi = ck_edge && !cs_l_s && (state == ST_WR) && !phase && !rwds_s;
      mem_wr_lo = ck_edge && !cs_l_s && (state == ST_WR) &&  phase && !rwds_s;
   end

   always_ff @(posedge clk) begin
      if (mem_wr_hi) mem_hi[idx] <= dq_s;
      if (mem_wr_lo) mem_lo[idx] <= dq_s;
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         ca             <= '0;
         addr           <= '0;
         is_rd          <= 1'b0;
         is_reg         <= 1'b0;
         is_wrap        <= 1'b0;
         phase          <= 1'b0;
         reg_hi         <= '0;
         dram_dq_out    <= '0;
         dram_dq_oe_l   <= 1'b1;
         dram_rwds_out  <= 1'b0;
         dram_rwds_oe_l <= 1'b1;
         cr0            <= CR0_RST;
      end else if (cs_l_s) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         dram_dq_oe_l   <= 1'b1;
         dram_rwds_out  <= 1'b0;
         dram_rwds_oe_l <= 1'b1;
      end else if (state == ST_IDLE) begin
         state <= ST_CA;
         cnt   <= '0;
      end else if (ck_edge) begin
         case (state)
            ST_CA: begin
               ca             <= ca_full[39:0];
               cnt            <= cnt + 8'd1;
               dram_rwds_oe_l <= 1'b0;
               dram_rwds_out  <= 1'b1;
               if (cnt == CA_LAST) begin
                  addr          <= ca_addr;
                  is_rd         <= ca_full[CA_RW_BIT];
                  is_reg        <= ca_full[CA_AS_BIT];
                  is_wrap       <= !ca_full[CA_BT_BIT];
                  cnt           <= '0;
                  phase         <= 1'b0;
                  dram_rwds_out <= 1'b0;
                  if (!ca_full[CA_RW_BIT] && ca_full[CA_AS_BIT]) begin
                     state          <= ST_REG_WR;
                     dram_rwds_oe_l <= 1'b1;
                  end else begin
                     state <= ST_LAT;
                  end
               end
            end
            ST_LAT: begin
               cnt <= cnt + 8'd1;
               if (cnt == LAT_LAST) begin
                  state          <= is_rd ? ST_RD : ST_WR;
                  dram_rwds_oe_l <= !is_rd;
               end
            end
            ST_REG_WR: begin
               if (cnt == 8'd0) begin
                  reg_hi <= dq_s;
                  cnt    <= 8'd1;
               end else if (cnt == 8'd1) begin
                  cnt <= 8'd2;
                  if (addr[11:0] == REG_CR0_ADDR) cr0 <= {reg_hi, dq_s};
               end
            end
            ST_RD: begin
               dram_dq_out   <= phase ? rd_word[7:0] : rd_word[15:8];
               dram_dq_oe_l  <= 1'b0;
               dram_rwds_out <= !dram_rwds_out;
               phase         <= !phase;
               if (phase) addr <= addr_next;
            end
            ST_WR: begin
               phase <= !phase;
               if (phase) addr <= addr_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hyper_target.sv
// Host-side bench for hyper_target: drives CA/latency/data on CK edges, keeps a
// word-array model of memory and CR0, and scoreboards every presented read byte.
module tb_hyper_target;

   localparam int unsigned MEM_WORDS = 1024;
   localparam int unsigned LAT_EDGES = 22;

   logic        clk = 1'b0;
   logic        reset_l = 1'b0;
   logic        dram_cs_l = 1'b1;
   logic        dram_ck = 1'b0;
   logic [7:0]  dram_dq_in = '0;
   logic        dram_rwds_in = 1'b0;
   logic [7:0]  dram_dq_out;
   logic        dram_dq_oe_l;
   logic        dram_rwds_out;
   logic        dram_rwds_oe_l;
   logic [15:0] cr0;

   hyper_target dut (
      .clk            (clk),
      .reset_l        (reset_l),
      .dram_cs_l      (dram_cs_l),
      .dram_ck        (dram_ck),
      .dram_dq_in     (dram_dq_in),
      .dram_dq_out    (dram_dq_out),
      .dram_dq_oe_l   (dram_dq_oe_l),
      .dram_rwds_in   (dram_rwds_in),
      .dram_rwds_out  (dram_rwds_out),
      .dram_rwds_oe_l (dram_rwds_oe_l),
      .cr0            (cr0)
   );

   always #5 clk = ~clk;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   logic [15:0] mem_m [MEM_WORDS];
   logic [15:0] cr0_m = 16'h8F1F;
   logic [8:0]  sbq[$];
   logic [8:0]  wbytes[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, got, exp);
   endtask

   function automatic int unsigned burst_addr(input int unsigned a, input int unsigned i,
                                              input logic wrap, input logic [1:0] bl);
      int unsigned len;
      if (!wrap) return (a + i) % MEM_WORDS;
      case (bl)
         2'd0:    len = 64;
         2'd1:    len = 32;
         2'd2:    len = 8;
         default: len = 16;
      endcase
      return ((a - (a % len)) + ((a % len) + i) % len) % MEM_WORDS;
   endfunction

   function automatic logic [47:0] make_ca(input logic rd, input logic as, input logic linear,
                                           input logic [31:0] a);
      return {rd, as, linear, a[31:3], 13'd0, a[2:0]};
   endfunction

   task automatic bus_edge(input logic [7:0] d, input logic r);
      dram_dq_in = d;
      dram_rwds_in = r;
      repeat (2) @(posedge clk);
      #1 dram_ck = ~dram_ck;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      dram_cs_l = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic bus_end();
      repeat (2) @(posedge clk);
      #1 dram_cs_l = 1'b1;
      repeat (4) @(posedge clk);
      #1 dram_ck = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_ca(input logic [47:0] ca);
      logic [47:0] sh;
      sh = ca;
      bus_start();
      for (int i = 0; i < 6; i++) begin
         bus_edge(sh[47:40], 1'b0);
         sh = sh << 8;
         if (i == 2) begin
            @(posedge clk);
            #1 check("ca_rwds_driven_high", {dram_rwds_oe_l, dram_rwds_out}, 32'b01);
         end
      end
   endtask

   task automatic push_word(input logic [15:0] w, input logic mhi, input logic mlo);
      wbytes.push_back({mhi, w[15:8]});
      wbytes.push_back({mlo, w[7:0]});
   endtask

   task automatic host_write(input logic [31:0] a, input logic wrap);
      int unsigned k;
      int unsigned wa;
      logic [8:0] b;
      k = 0;
      send_ca(make_ca(1'b0, 1'b0, !wrap, a));
      repeat (LAT_EDGES) bus_edge(8'h00, 1'b0);
      while (wbytes.size() > 0) begin
         b = wbytes.pop_front();
         wa = burst_addr(a, k / 2, wrap, cr0_m[1:0]);
         if (!b[8]) begin
            if (k % 2 == 0) mem_m[wa][15:8] = b[7:0];
            else            mem_m[wa][7:0]  = b[7:0];
         end
         bus_edge(b[7:0], b[8]);
         k++;
      end
      bus_end();
   endtask

   task automatic host_read(input logic [31:0] a, input logic wrap, input logic reg_space,
                            input int unsigned nwords);
      logic [15:0] w;
      for (int unsigned i = 0; i < nwords; i++) begin
         if (reg_space)
            w = (a[11:0] == 12'h000) ? 16'h0C81 : (a[11:0] == 12'h800) ? cr0_m : 16'h0000;
         else
            w = mem_m[burst_addr(a, i, wrap, cr0_m[1:0])];
         sbq.push_back({1'b1, w[15:8]});
         sbq.push_back({1'b0, w[7:0]});
      end
      send_ca(make_ca(1'b1, reg_space, !wrap, a));
      repeat (LAT_EDGES) bus_edge(8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1 check("lat_dq_oe_still_high", dram_dq_oe_l, 1);
      for (int unsigned k = 0; k < 2 * nwords; k++) begin
         bus_edge(8'h00, 1'b0);
         if (k == 0) begin
            @(posedge clk);
            #1 check("first_byte_oe_low", dram_dq_oe_l, 0);
         end
      end
      bus_end();
   endtask

   task automatic host_reg_write(input logic [31:0] a, input logic [15:0] v);
      send_ca(make_ca(1'b0, 1'b1, 1'b1, a));
      bus_edge(v[15:8], 1'b0);
      bus_edge(v[7:0], 1'b0);
      bus_end();
      if (a[11:0] == 12'h800) cr0_m = v;
      check("cr0_after_reg_write", cr0, cr0_m);
   endtask

   // Scoreboard: a new byte is presented when DQ becomes driven or RWDS toggles while driven.
   initial begin : monitor
      logic prev_oe_l;
      logic prev_rwds;
      logic [8:0] e;
      int unsigned nb;
      prev_oe_l = 1'b1;
      prev_rwds = 1'b0;
      nb = 0;
      forever begin
         @(negedge clk);
         if (!dram_dq_oe_l && (prev_oe_l || dram_rwds_out != prev_rwds)) begin
            if (sbq.size() == 0) begin
               n_total++;
               $display("FAIL sb_unexpected_byte: got dq=%h rwds=%b required no byte",
                        dram_dq_out, dram_rwds_out);
            end else begin
               e = sbq.pop_front();
               check($sformatf("sb_rd_byte%0d", nb), {23'd0, dram_rwds_out, dram_dq_out}, {23'd0, e});
            end
            nb++;
         end
         prev_oe_l = dram_dq_oe_l;
         prev_rwds = dram_rwds_out;
      end
   end

   initial begin : stim
      logic [47:0] sh;
      logic [31:0] a;
      int unsigned op;
      int unsigned n;

      repeat (3) @(posedge clk);
      #1;
      check("rst_dq_out", dram_dq_out, 0);
      check("rst_dq_oe_l", dram_dq_oe_l, 1);
      check("rst_rwds_out", dram_rwds_out, 0);
      check("rst_rwds_oe_l", dram_rwds_oe_l, 1);
      check("rst_cr0", cr0, 16'h8F1F);
      reset_l = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      for (int unsigned i = 0; i < MEM_WORDS; i++) push_word(16'($urandom), 1'b0, 1'b0);
      host_write(32'd0, 1'b0);

      push_word(16'hA5A5, 1'b0, 1'b0);
      push_word(16'h1234, 1'b0, 1'b0);
      host_write(32'h10, 1'b0);
      host_read(32'h10, 1'b0, 1'b0, 2);

      push_word(16'h0000, 1'b0, 1'b0);
      push_word(16'h0000, 1'b0, 1'b0);
      host_write(32'h20, 1'b0);
      push_word(16'hFFFF, 1'b1, 1'b0);
      push_word(16'hFFFF, 1'b1, 1'b0);
      host_write(32'h20, 1'b0);
      host_read(32'h20, 1'b0, 1'b0, 2);

      host_read(MEM_WORDS - 1, 1'b0, 1'b0, 2);

      host_reg_write(32'h800, 16'h8F1E);
      host_read(32'd5, 1'b1, 1'b0, 8);

      host_read(32'h000, 1'b0, 1'b1, 1);
      host_read(32'h800, 1'b0, 1'b1, 1);
      host_reg_write(32'h000, 16'h1234);
      host_read(32'h000, 1'b0, 1'b1, 1);

      // Abort after three CA edges, then a clean full read.
      sh = make_ca(1'b1, 1'b0, 1'b1, 32'h33);
      bus_start();
      for (int i = 0; i < 3; i++) begin
         bus_edge(sh[47:40], 1'b0);
         sh = sh << 8;
      end
      @(posedge clk);
      #1 check("abort_pre_rwds_oe_low", dram_rwds_oe_l, 0);
      dram_cs_l = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_rwds_oe_high", dram_rwds_oe_l, 1);
      check("abort_dq_oe_high", dram_dq_oe_l, 1);
      repeat (4) @(posedge clk);
      #1 dram_ck = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      host_read(32'h33, 1'b0, 1'b0, 4);

      // Write aborted mid-word keeps only the completed bytes.
      push_word(16'hBEEF, 1'b0, 1'b0);
      wbytes.push_back({1'b0, 8'hC3});
      host_write(32'h40, 1'b0);
      host_read(32'h40, 1'b0, 1'b0, 2);

      for (int it = 0; it < 12; it++) begin
         op = $urandom_range(0, 3);
         a = 32'($urandom_range(0, MEM_WORDS - 1));
         if (op <= 1) begin
            host_read(a, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 24));
         end else if (op == 2) begin
            n = $urandom_range(1, 40);
            for (int unsigned k = 0; k < n; k++)
               wbytes.push_back({($urandom_range(0, 3) == 0), 8'($urandom)});
            host_write(a, 1'($urandom_range(0, 1)));
         end else begin
            host_reg_write(32'h800, 16'($urandom));
         end
      end

      // Reset during read latency returns outputs and CR0 to reset values at once.
      send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h7));
      repeat (5) bus_edge(8'h00, 1'b0);
      @(posedge clk);
      #1 reset_l = 1'b0;
      #1;
      check("midop_rst_dq_oe_l", dram_dq_oe_l, 1);
      check("midop_rst_rwds_oe_l", dram_rwds_oe_l, 1);
      check("midop_rst_dq_out", dram_dq_out, 0);
      check("midop_rst_cr0", cr0, 16'h8F1F);
      dram_cs_l = 1'b1;
      dram_ck = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset_l = 1'b1;
      cr0_m = 16'h8F1F;
      repeat (4) @(posedge clk);
      #1;
      host_read(32'h10, 1'b0, 1'b0, 2);

      repeat (20) @(posedge clk);
      check("sb_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
